// File: rtl/sa_pkg.sv
// Shared types and cycle-count helpers for the systolic-array operand feeder.
package sa_pkg;

  localparam int unsigned SaN     = 4;
  localparam int unsigned SaWdata = 4;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} feed_state_e;

  typedef logic [SaN-1:0][SaWdata-1:0] lane_vec_t;

  function automatic int unsigned feed_cycles(input int unsigned k);
    return 2 * k - 1;
  endfunction

  function automatic int unsigned flush_cycles(input int unsigned k);
    return k;
  endfunction

endpackage

// File: rtl/sa_operand_buf.sv
// N x N operand register file: one write port, N independent read ports.
module sa_operand_buf #(
  parameter int unsigned N     = 4,
  parameter int unsigned WDATA = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               we_i,
  input  logic [$clog2(N)-1:0]               wr_row_i,
  input  logic [$clog2(N)-1:0]               wr_col_i,
  input  logic [WDATA-1:0]                   wr_data_i,
  input  logic [N-1:0][$clog2(N)-1:0]        rd_row_i,
  input  logic [N-1:0][$clog2(N)-1:0]        rd_col_i,
  output logic [N-1:0][WDATA-1:0]            rd_data_o
);

  logic [N-1:0][N-1:0][WDATA-1:0] mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int p = 0; p < int'(N); p++) begin
      rd_data_o[p] = mem_q[rd_row_i[p]][rd_col_i[p]];
    end
  end

endmodule

// File: rtl/sa_skew_feeder.sv
// Buffers A/B, then drives diagonally skewed West/North operand streams into the SA.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WDATA = 4,
  parameter int unsigned CW    = $clog2(3 * N + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ld_valid_i,
  output logic                       ld_ready_o,
  input  logic                       ld_sel_i,
  input  logic [$clog2(N)-1:0]       ld_row_i,
  input  logic [$clog2(N)-1:0]       ld_col_i,
  input  logic [WDATA-1:0]           ld_data_i,
  input  logic [$clog2(N+1)-1:0]     cfg_k_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [$clog2(N+1)-1:0]     row_cfg_o,
  output logic [$clog2(N+1)-1:0]     col_cfg_o,
  output logic                       sa_clr_no,
  output logic [N-1:0][WDATA-1:0]    matrix_w_o,
  output logic [N-1:0][WDATA-1:0]    matrix_n_o
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned KW = $clog2(N + 1);

  feed_state_e                 state_q;
  logic [CW-1:0]               t_q;
  logic [KW-1:0]               k_q;
  logic                        err_q;
  logic [N-1:0][WDATA-1:0]     w_q, n_q, w_d, n_d;

  logic                        we_a, we_b, cfg_ok;
  logic [CW-1:0]               t_last;
  logic [N-1:0][IW-1:0]        a_row, a_col, b_row, b_col;
  logic [N-1:0][WDATA-1:0]     a_rd, b_rd;
  logic [N-1:0]                lane_en;
  int                          rd_t;
  int                          lane_k [N];

  assign ld_ready_o = (state_q == IDLE) || (state_q == DONE);
  assign busy_o     = (state_q == CLEAR) || (state_q == FEED) || (state_q == FLUSH);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;
  assign sa_clr_no  = (state_q != CLEAR);
  assign row_cfg_o  = k_q;
  assign col_cfg_o  = k_q;
  assign matrix_w_o = w_q;
  assign matrix_n_o = n_q;

  assign we_a   = ld_valid_i && ld_ready_o && !ld_sel_i;
  assign we_b   = ld_valid_i && ld_ready_o && ld_sel_i;
  assign cfg_ok = (cfg_k_i != '0) && (32'(cfg_k_i) <= N);

  assign t_last = (state_q == FEED) ? CW'(feed_cycles(32'(k_q)) - 1)
                                    : CW'(flush_cycles(32'(k_q)) - 1);

  // Lanes are computed for the slot being entered, so reads look one t ahead.
  always_comb begin
    rd_t  = (state_q == CLEAR) ? 0 : int'(t_q) + 1;
    a_row = '0;
    a_col = '0;
    b_row = '0;
    b_col = '0;
    w_d   = '0;
    n_d   = '0;
    for (int i = 0; i < int'(N); i++) begin
      lane_k[i]  = rd_t - i;
      lane_en[i] = (i < int'(k_q)) && (lane_k[i] >= 0) && (lane_k[i] < int'(k_q));
      a_row[i]   = IW'(i);
      a_col[i]   = lane_en[i] ? IW'(lane_k[i]) : '0;
      b_row[i]   = a_col[i];
      b_col[i]   = IW'(i);
      w_d[i]     = lane_en[i] ? a_rd[i] : '0;
      n_d[i]     = lane_en[i] ? b_rd[i] : '0;
    end
  end

  sa_operand_buf #(.N(N), .WDATA(WDATA)) u_buf_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (we_a),
    .wr_row_i  (ld_row_i),
    .wr_col_i  (ld_col_i),
    .wr_data_i (ld_data_i),
    .rd_row_i  (a_row),
    .rd_col_i  (a_col),
    .rd_data_o (a_rd)
  );

  sa_operand_buf #(.N(N), .WDATA(WDATA)) u_buf_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .we_i      (we_b),
    .wr_row_i  (ld_row_i),
    .wr_col_i  (ld_col_i),
    .wr_data_i (ld_data_i),
    .rd_row_i  (b_row),
    .rd_col_i  (b_col),
    .rd_data_o (b_rd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= KW'(N);
      err_q   <= 1'b0;
      w_q     <= '0;
      n_q     <= '0;
    end else begin
      err_q <= 1'b0;
      w_q   <= '0;
      n_q   <= '0;
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            if (cfg_ok) begin
              k_q     <= cfg_k_i;
              state_q <= CLEAR;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state_q <= FEED;
          t_q     <= '0;
          w_q     <= w_d;
          n_q     <= n_d;
        end
        FEED: begin
          if (t_q == t_last) begin
            state_q <= FLUSH;
            t_q     <= '0;
          end else begin
            t_q <= t_q + 1'b1;
            w_q <= w_d;
            n_q <= n_d;
          end
        end
        FLUSH: begin
          if (t_q == t_last) begin
            state_q <= DONE;
            t_q     <= '0;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench: expected lane streams are queued at start, a monitor pops and compares.
module tb_sa_skew_feeder;

  localparam int unsigned N     = 4;
  localparam int unsigned WDATA = 4;

  typedef logic [N-1:0][WDATA-1:0] lanes_t;
  typedef struct packed {
    lanes_t w;
    lanes_t n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         ld_valid, ld_ready, ld_sel;
  logic [1:0]   ld_row, ld_col;
  logic [3:0]   ld_data;
  logic [2:0]   cfg_k;
  logic         start, busy, done, err, sa_clr_n;
  logic [2:0]   row_cfg, col_cfg;
  lanes_t       matrix_w, matrix_n;

  exp_t exp_q[$];
  exp_t mon_e;
  int   a_m [N][N];
  int   b_m [N][N];
  int   acc [N][N];
  int   ah  [N][N];
  int   bh  [N][N];
  int   a_in, b_in;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sa_skew_feeder #(.N(N), .WDATA(WDATA)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .ld_sel_i   (ld_sel),
    .ld_row_i   (ld_row),
    .ld_col_i   (ld_col),
    .ld_data_i  (ld_data),
    .cfg_k_i    (cfg_k),
    .start_i    (start),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .row_cfg_o  (row_cfg),
    .col_cfg_o  (col_cfg),
    .sa_clr_no  (sa_clr_n),
    .matrix_w_o (matrix_w),
    .matrix_n_o (matrix_n)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Behavioural output-stationary array driven by the DUT lanes.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni || !sa_clr_n) begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(N); j++) begin
          acc[i][j] <= 0;
          ah[i][j]  <= 0;
          bh[i][j]  <= 0;
        end
    end else begin
      for (int i = 0; i < int'(N); i++)
        for (int j = 0; j < int'(N); j++) begin
          if (j == 0) a_in = int'(matrix_w[i]);
          else        a_in = ah[i][j-1];
          if (i == 0) b_in = int'(matrix_n[j]);
          else        b_in = bh[i-1][j];
          acc[i][j] <= acc[i][j] + a_in * b_in;
          ah[i][j]  <= a_in;
          bh[i][j]  <= b_in;
        end
    end
  end

  // Monitor: every FEED/FLUSH cycle consumes one expected lane pair.
  always @(negedge clk) begin
    if (rst_ni && busy && sa_clr_n) begin
      if (exp_q.size() == 0) begin
        check("stream_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("lane_W", 64'(matrix_w), 64'(mon_e.w));
        check("lane_N", 64'(matrix_n), 64'(mon_e.n));
      end
    end
  end

  function automatic exp_t mk(input int w0, input int w1, input int n0, input int n1);
    exp_t e = '0;
    e.w[0] = WDATA'(w0);
    e.w[1] = WDATA'(w1);
    e.n[0] = WDATA'(n0);
    e.n[1] = WDATA'(n1);
    return e;
  endfunction

  task automatic push_expect(input int k);
    exp_t e;
    for (int t = 0; t <= 2 * k - 2; t++) begin
      e = '0;
      for (int i = 0; i < k; i++) begin
        if (t - i >= 0 && t - i < k) begin
          e.w[i] = WDATA'(a_m[i][t-i]);
          e.n[i] = WDATA'(b_m[t-i][i]);
        end
      end
      exp_q.push_back(e);
    end
    for (int f = 0; f < k; f++) exp_q.push_back('0);
  endtask

  task automatic wr(input logic sel, input int row, input int col, input int data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = 2'(row);
    ld_col   = 2'(col);
    ld_data  = 4'(data);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    if (sel) b_m[row][col] = data;
    else     a_m[row][col] = data;
  endtask

  task automatic run(input int k, input bit inject);
    int cnt;
    cfg_k = 3'(k);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt   = 0;
    while (cnt < 3 * k + 10 && !done) begin
      @(posedge clk);
      #1;
      cnt++;
      if (inject && cnt == 3) begin
        check("ld_ready_busy", 64'(ld_ready), 64'd0);
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_col   = 2'd0;
        ld_data  = 4'd9;
        start    = 1'b1;
        cfg_k    = 3'd1;
        @(posedge clk);
        #1;
        cnt++;
        ld_valid = 1'b0;
        start    = 1'b0;
        check("err_busy", 64'(err), 64'd0);
      end
    end
    check("done_latency", 64'(cnt), 64'(3 * k));
    check("row_cfg", 64'(row_cfg), 64'(k));
    check("col_cfg", 64'(col_cfg), 64'(k));
    check("lanes_done", 64'({matrix_w, matrix_n}), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_c(input int k);
    int s;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++) begin
        s = 0;
        for (int x = 0; x < k; x++) s += a_m[i][x] * b_m[x][j];
        check($sformatf("C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(s));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni   = 1'b0;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_row   = '0;
    ld_col   = '0;
    ld_data  = '0;
    cfg_k    = '0;
    start    = 1'b0;
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_clr_n", 64'(sa_clr_n), 64'd1);
    check("rst_ready", 64'(ld_ready), 64'd1);
    check("rst_row_cfg", 64'(row_cfg), 64'd4);
    check("rst_col_cfg", 64'(col_cfg), 64'd4);
    check("rst_lanes", 64'({matrix_w, matrix_n}), 64'd0);

    // Rejected starts: cfg_k = 0 and cfg_k = 5.
    for (int v = 0; v < 2; v++) begin
      cfg_k = (v == 0) ? 3'd0 : 3'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("err_pulse", 64'(err), 64'd1);
      check("err_busy0", 64'(busy), 64'd0);
      check("err_idle_ready", 64'(ld_ready), 64'd1);
      @(posedge clk);
      #1;
      check("err_one_cycle", 64'(err), 64'd0);
      check("err_not_done", 64'(done), 64'd0);
    end

    // K=2 hand-computed stream and product.
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
    wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
    exp_q.push_back(mk(1, 0, 5, 0));
    exp_q.push_back(mk(2, 3, 7, 6));
    exp_q.push_back(mk(0, 4, 0, 8));
    exp_q.push_back('0);
    exp_q.push_back('0);
    run(2, 1'b0);
    check("C00_hand", 64'(acc[0][0]), 64'd19);
    check("C01_hand", 64'(acc[0][1]), 64'd22);
    check("C10_hand", 64'(acc[1][0]), 64'd43);
    check("C11_hand", 64'(acc[1][1]), 64'd50);

    // K=4 all fifteen, started from DONE.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        wr(0, i, j, 15);
        wr(1, i, j, 15);
      end
    push_expect(4);
    run(4, 1'b1 == 1'b0);
    check("C33_900", 64'(acc[3][3]), 64'd900);
    check_c(4);

    // K=3 random; row/col 3 still hold 15 and must never reach the lanes.
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        wr(0, i, j, int'($urandom_range(0, 15)));
        wr(1, i, j, int'($urandom_range(0, 15)));
      end
    push_expect(3);
    run(3, 1'b1);
    check_c(3);

    // Asynchronous reset at FEED t=2.
    cfg_k = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_expect(2);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_lanes", 64'({matrix_w, matrix_n}), 64'd0);
    check("mid_rst_cfg", 64'(row_cfg), 64'd4);
    check("mid_rst_clr_n", 64'(sa_clr_n), 64'd1);
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
        a_m[i][j] = 0;
        b_m[i][j] = 0;
      end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    wr(0, 0, 0, 2); wr(0, 0, 1, 3); wr(0, 1, 0, 1); wr(0, 1, 1, 4);
    wr(1, 0, 0, 6); wr(1, 0, 1, 1); wr(1, 1, 0, 2); wr(1, 1, 1, 5);
    push_expect(2);
    run(2, 1'b0);
    check_c(2);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
Name: sa_skew_feeder

Overview:
- Parametrised operand sequencer for the N x N output-stationary systolic array (SA).
- Buffers matrix A and matrix B for a run-time size K (1..N), then emits the diagonally skewed West/North operand streams.
- Drives the array configuration, clears the accumulators, flushes the pipeline, and flags when matrix_out holds C = A x B.
- Replaces hand-written per-cycle drive sequences: one block serves every K up to N.

Parameters:
- N, 4, array dimension; maximum supported K.
- WDATA, 4, operand width in bits.
- CW, $clog2(3*N+1), internal cycle-counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  operand write strobe.
- ld_ready  out  1  high when writes are accepted (IDLE or DONE only).
- ld_sel  in  1  0 = matrix A, 1 = matrix B.
- ld_row  in  $clog2(N)  0-based row index.
- ld_col  in  $clog2(N)  0-based column index.
- ld_data  in  WDATA  operand value.
- cfg_k  in  $clog2(N+1)  matrix size; sampled only on an accepted start.
- start  in  1  one-cycle request to run.
- busy  out  1  high in CLEAR, FEED and FLUSH.
- done  out  1  high in DONE; SA matrix_out is valid.
- err  out  1  one-cycle pulse when start is rejected.
- row_cfg_out  out  $clog2(N+1)  to SA row_cfg_in; holds the latched K.
- col_cfg_out  out  $clog2(N+1)  to SA col_cfg_in; holds the latched K.
- sa_clr_n  out  1  active-low accumulator clear to the SA.
- matrix_W  out  N x WDATA  West lanes (A operands).
- matrix_N  out  N x WDATA  North lanes (B operands).

Behaviour:
- Reset values:
  - State IDLE.
  - matrix_W and matrix_N all 0.
  - busy = 0, done = 0, err = 0, sa_clr_n = 1.
  - row_cfg_out = col_cfg_out = N.
  - Operand buffers cleared to 0.
- Load path:
  - A write occurs when ld_valid && ld_ready; it takes effect the next cycle.
  - Writes outside IDLE/DONE are dropped because ld_ready = 0.
  - Indices >= K are stored but never fed.
- start acceptance:
  - start in IDLE or DONE with 1 <= cfg_k <= N: latch K, drive row_cfg_out/col_cfg_out = K, go to CLEAR.
  - cfg_k of 0 or > N: pulse err for one cycle, state unchanged.
  - start during busy is ignored; no err.
- State CLEAR (1 cycle): sa_clr_n = 0, lanes 0. Then FEED with t = 0.
- State FEED (2K-1 cycles, t = 0..2K-2):
  - For lane i < K: let k = t - i. If 0 <= k < K, then W[i] = A[i][k] and N[i] = B[k][i]; otherwise the lane is 0.
  - Lanes i >= K are always 0.
  - Outputs are registered and change on the clock edge that enters each t.
- State FLUSH (K cycles): all lanes 0, so the last operand pair reaches PE(K-1,K-1) and accumulates.
- State DONE:
  - done = 1; lanes 0.
  - K and the cfg outputs are held until the next accepted start.
  - done drops on the cycle CLEAR is entered.
- Latency: start accepted at edge 0 → done high 1 + (2K-1) + K = 3K cycles later.
- Asynchronous reset mid-run: immediate return to IDLE with all reset values. Buffer contents are lost and must be reloaded.
- Simultaneous ld_valid and start in IDLE/DONE: the write commits, and feeding uses the updated value. The buffer write has priority in the same edge; the first FEED read is two cycles later.

Decomposition:
- sa_pkg holds:
  - typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} feed_state_e.
  - typedef for a lane vector logic [N-1:0][WDATA-1:0].
  - localparam functions for feed_cycles(K) = 2K-1 and flush_cycles(K) = K.
- One sub-module, sa_operand_buf: N x N register file with one write port and N parallel read ports indexed by (i, t-i), instantiated twice (A, B).
- The FSM, counter and skew-index logic stay in sa_skew_feeder.

Test Plan:
- K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → W/N per FEED cycle: t0 W=(1,0) N=(5,0); t1 W=(2,3) N=(7,6); t2 W=(0,4) N=(0,8). done 6 cycles after start; SA out [[19,22],[43,50]].
- K=4, all A=B=15 → 7 FEED + 4 FLUSH cycles; done at start+12; every C[i][j] = 900; lanes never nonzero outside the skew window.
- K=3 on N=4 with random A/B → lane 3 always 0; row_cfg_out = col_cfg_out = 3; SA out matches the reference product.
- start with cfg_k=0, then cfg_k=5 → err pulses each time, state stays IDLE, busy = 0.
- start and ld_valid pulsed during FEED → both ignored, ld_ready = 0, no err, result unchanged.
- rst_n low at FEED t=2 → all outputs at reset values immediately; a new load plus start then completes correctly.
